// File: rtl/riscv_dbg_pkg.sv
// Shared debug types for the register dump unit: FSM states, halt encoding
// and the packed word carried on the dump stream.
package riscv_dbg_pkg;

  typedef enum logic [2:0] {
    RUN,
    READ,
    SEND,
    CSUM,
    DONE
  } dump_state_t;

  // jal x0,0 : the terminal self-loop every test program ends on
  localparam logic [31:0] HALT_JAL_SELF = 32'h0000006F;

  localparam int DUMP_REGS       = 32;
  localparam int DUMP_MIN_RETIRE = 6;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        is_csum;
    logic        last;
  } dbg_word_t;

  // Halt match only counts once the core has retired enough instructions,
  // so a program that starts on a self-loop does not dump immediately.
  function automatic logic is_halt_match(input logic        valid,
                                         input logic [31:0] instr,
                                         input logic [31:0] halt_instr,
                                         input logic        armed);
    return valid && (instr == halt_instr) && armed;
  endfunction

endpackage

// File: rtl/reg_dump_unit.sv
// End-of-program register dumper: freezes the core, walks the register file
// through a debug read port and streams every register plus a checksum.
module reg_dump_unit
  import riscv_dbg_pkg::*;
#(
  parameter logic [31:0] HALT_INSTR = HALT_JAL_SELF,
  parameter int          MIN_RETIRE = DUMP_MIN_RETIRE,
  parameter int          NUM_REGS   = DUMP_REGS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  input  logic        dump_req,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        cpu_halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_is_csum,
  output logic        out_last,
  output logic        done
);

  // Stream handshake: a word transfers on a rising clk edge where
  // out_valid && out_ready; once out_valid is high the word and its flags
  // hold until that edge, and out_ready is ignored while out_valid is low.

  localparam int             CNT_W     = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_RETIRE);
  localparam logic [4:0]     LAST_IDX  = 5'(NUM_REGS - 1);

  dump_state_t      state;
  logic [CNT_W-1:0] retire_cnt;
  logic [4:0]       index;
  logic [31:0]      csum;
  dbg_word_t        word;
  logic             out_valid_q;
  logic             cpu_halt_q;
  logic             done_q;

  logic        halt_hit;
  logic        trigger;
  logic        fire;
  logic [31:0] rd_value;
  logic [31:0] csum_next;

  always_comb begin
    halt_hit  = is_halt_match(instr_valid, instruction, HALT_INSTR,
                              retire_cnt >= MIN_CNT);
    trigger   = halt_hit || dump_req;
    fire      = out_valid_q && out_ready;
    // x0 is hardwired zero regardless of what the read port returns
    rd_value  = (index == 5'd0) ? 32'd0 : rf_rdata;
    csum_next = csum + word.data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      retire_cnt  <= '0;
      index       <= '0;
      csum        <= '0;
      word        <= '0;
      out_valid_q <= 1'b0;
      cpu_halt_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (instr_valid && (retire_cnt != CNT_MAX))
            retire_cnt <= retire_cnt + 1'b1;
          if (trigger) begin
            state      <= READ;
            cpu_halt_q <= 1'b1;
            index      <= '0;
            csum       <= '0;
          end
        end
        READ: begin
          word        <= '{data: rd_value, idx: index, is_csum: 1'b0, last: 1'b0};
          out_valid_q <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (fire) begin
            csum <= csum_next;
            if (index == LAST_IDX) begin
              // checksum word follows back-to-back, valid stays high
              word  <= '{data: csum_next, idx: 5'd0, is_csum: 1'b1, last: 1'b1};
              state <= CSUM;
            end else begin
              index       <= index + 1'b1;
              out_valid_q <= 1'b0;
              state       <= READ;
            end
          end
        end
        CSUM: begin
          if (fire) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          cpu_halt_q <= 1'b1;
          done_q     <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign rf_raddr    = index;
  assign cpu_halt    = cpu_halt_q;
  assign out_valid   = out_valid_q;
  assign out_data    = word.data;
  assign out_idx     = word.idx;
  assign out_is_csum = word.is_csum;
  assign out_last    = word.last;
  assign done        = done_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboarded bench for reg_dump_unit: a register-file model feeds the
// debug port, expected dumps are queued on trigger and popped per handshake.
module tb_reg_dump_unit;
  import riscv_dbg_pkg::*;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] HALT = 32'h0000006F;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        dump_req;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        cpu_halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_is_csum;
  logic        out_last;
  logic        done;

  logic [31:0] rf [32];
  logic [38:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          ready_mode = 0;

  assign rf_rdata = rf[rf_raddr];

  reg_dump_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .instr_valid(instr_valid), .dump_req(dump_req), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .cpu_halt(cpu_halt), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_is_csum(out_is_csum), .out_last(out_last), .done(done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {17'd0, cpu_halt, out_valid, out_data, out_idx, out_is_csum,
            out_last, done, rf_raddr};
  endfunction

  // Reference dump: x0 reads as zero, checksum is the plain 32-bit sum.
  task automatic push_dump();
    logic [31:0] sum = 32'd0;
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? 32'd0 : rf[i];
      sum += v;
      exp_q.push_back({v, 5'(i), 1'b0, 1'b0});
    end
    exp_q.push_back({sum, 5'd0, 1'b1, 1'b1});
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11111111;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEADBEEF;
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    dump_req = 1'b0;
    step();
    check("reset_outputs", all_outputs(), 64'd0);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic retire(input logic [31:0] instr);
    instruction = instr;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instruction = NOP;
  endtask

  task automatic pulse_dump_req();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check("done_reached", done, 1);
    check("cpu_halt_in_done", cpu_halt, 1);
    check("stream_complete", exp_q.size(), 0);
  endtask

  // ---------------- sink ready generator ----------------
  initial begin
    int rdy_cnt = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (rdy_cnt % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      rdy_cnt++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        held_v = 1'b0;
    logic [38:0] held_w = '0;
    logic [38:0] cur;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_v = 1'b0;
      end else if (out_valid) begin
        cur = {out_data, out_idx, out_is_csum, out_last};
        if (held_v) check("hold_stable", cur, held_w);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got 0x%0h expected none", cur);
          end else begin
            check("stream_word", cur, exp_q.pop_front());
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_w = cur;
        end
      end else begin
        if (held_v) check("valid_drop", 0, 1);
        held_v = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1;
    instruction = NOP;
    instr_valid = 1'b0;
    dump_req = 1'b0;
    #1;

    // Halt encoding ignored before MIN_RETIRE, honoured at count 6
    do_reset();
    fill_pattern();
    ready_mode = 0;
    repeat (3) retire(NOP);
    retire(HALT);
    check("early_halt_ignored", cpu_halt, 0);
    retire(NOP);
    retire(NOP);
    push_dump();
    retire(HALT);
    check("halt_next_cycle", cpu_halt, 1);
    check("valid_low_in_read", out_valid, 0);
    wait_done(300);

    // Same image, slow sink: identical stream and checksum
    do_reset();
    fill_pattern();
    ready_mode = 1;
    push_dump();
    pulse_dump_req();
    check("req_halts_core", cpu_halt, 1);
    wait_done(500);

    // dump_req at cycle 2 with a halt encoding present, count below threshold
    do_reset();
    fill_random();
    ready_mode = 2;
    step();
    push_dump();
    instruction = HALT;
    instr_valid = 1'b1;
    pulse_dump_req();
    instr_valid = 1'b0;
    check("early_req_halts", cpu_halt, 1);
    wait_done(600);

    // dump_req coinciding with a real halt match: exactly one dump
    do_reset();
    fill_random();
    ready_mode = 2;
    n = $urandom_range(6, 10);
    repeat (n) retire(NOP);
    check("no_halt_before_trigger", cpu_halt, 0);
    push_dump();
    instruction = HALT;
    instr_valid = 1'b1;
    pulse_dump_req();
    instr_valid = 1'b0;
    wait_done(600);

    // Reset while presenting idx 10, then a fresh dump from idx 0
    do_reset();
    fill_random();
    ready_mode = 0;
    push_dump();
    pulse_dump_req();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_idx == 5'd10) && n < 200);
    check("reached_idx10", out_valid && (out_idx == 5'd10), 1);
    #1 reset = 1'b1;
    #1 check("reset_mid_dump", all_outputs(), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    fill_random();
    push_dump();
    pulse_dump_req();
    wait_done(300);

    // DONE is sticky: further requests and halts are ignored
    for (int i = 0; i < 8; i++) begin
      dump_req = 1'(i % 2);
      instruction = HALT;
      instr_valid = 1'b1;
      step();
      check("done_sticky", {out_valid, done, cpu_halt}, 3'b011);
    end
    dump_req = 1'b0;
    instr_valid = 1'b0;
    repeat (4) step();
    check("no_extra_words", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
